// File: rtl/alu_response_checker.sv
// In-flight response checker for the 8-bit alu: golden model, latency-matched expectation pipeline, pass/fail/skip counters.
// Optional first-failure capture ports are enabled by defining ALU_CHK_FIRST_FAIL_EN.
//
// state | meaning
// IDLE  | after reset, nothing sampled
// RUN   | sampling in_valid operands and comparing
// DRAIN | no new samples, in-flight entries still compared
// DONE  | pipeline empty, results final
module alu_response_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [3:0]       ALU_Sel,
  input  logic [7:0]       ALU_Out,
  input  logic             CarryOut,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             error,
  output logic             busy,
  output logic             done
`ifdef ALU_CHK_FIRST_FAIL_EN
  ,
  output logic [7:0]       ff_A,
  output logic [7:0]       ff_B,
  output logic [3:0]       ff_sel,
  output logic [8:0]       ff_exp,
  output logic [8:0]       ff_act
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0] prod;
  logic [8:0]  gold;
  logic        gold_skip;
  logic        ins;
  logic        rest_empty;
  logic        pv [LATENCY];
  logic        ps [LATENCY];
  logic [8:0]  pe [LATENCY];
`ifdef ALU_CHK_FIRST_FAIL_EN
  logic [19:0] pop [LATENCY];
`endif

  always_comb begin
    prod      = 16'(A) * 16'(B);
    gold      = '0;
    gold_skip = 1'b0;
    case (ALU_Sel)
      4'b0000: gold = {1'b0, A} + {1'b0, B};
      4'b0001: gold = {1'b0, A} - {1'b0, B};
      4'b0010: gold = {|prod[15:8], prod[7:0]};
      4'b0011: begin
        if (B != 8'd0) gold = {1'b0, A / B};
        else           gold_skip = 1'b1;
      end
      default: gold_skip = 1'b1;
    endcase
  end

  assign ins = (state == RUN) && in_valid && !start && !stop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv[i] <= 1'b0;
        ps[i] <= 1'b0;
        pe[i] <= '0;
`ifdef ALU_CHK_FIRST_FAIL_EN
        pop[i] <= '0;
`endif
      end
    end else if (start) begin
      for (int i = 0; i < LATENCY; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= ins;
      ps[0] <= gold_skip;
      pe[0] <= gold;
`ifdef ALU_CHK_FIRST_FAIL_EN
      pop[0] <= {A, B, ALU_Sel};
`endif
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pe[i] <= pe[i-1];
`ifdef ALU_CHK_FIRST_FAIL_EN
        pop[i] <= pop[i-1];
`endif
      end
    end
  end

  // X/Z on ALU_Out makes the equality unknown, which takes the fail branch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
      error    <= 1'b0;
`ifdef ALU_CHK_FIRST_FAIL_EN
      ff_A <= '0; ff_B <= '0; ff_sel <= '0; ff_exp <= '0; ff_act <= '0;
`endif
    end else if (start) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
      error    <= 1'b0;
`ifdef ALU_CHK_FIRST_FAIL_EN
      ff_A <= '0; ff_B <= '0; ff_sel <= '0; ff_exp <= '0; ff_act <= '0;
`endif
    end else if (pv[LATENCY-1]) begin
      if (ps[LATENCY-1]) begin
        if (skip_cnt != {CNT_W{1'b1}}) skip_cnt <= skip_cnt + CNT_W'(1);
      end else if ({CarryOut, ALU_Out} == pe[LATENCY-1]) begin
        if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
        error <= 1'b1;
`ifdef ALU_CHK_FIRST_FAIL_EN
        if (!error) begin
          ff_A   <= pop[LATENCY-1][19:12];
          ff_B   <= pop[LATENCY-1][11:4];
          ff_sel <= pop[LATENCY-1][3:0];
          ff_exp <= pe[LATENCY-1];
          ff_act <= {CarryOut, ALU_Out};
        end
`endif
      end
    end
  end

  // The exit stage is consumed this cycle, so only the upstream stages decide emptiness.
  always_comb begin
    rest_empty = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++) begin
      if (pv[i]) rest_empty = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (stop) state_nxt = DRAIN;
        DRAIN:   if (rest_empty) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench: three checkers (LATENCY 1, LATENCY 4, CNT_W 2) beside a behavioural alu with a fault-inject hook.
module tb_alu_response_checker;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0, fault = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [3:0] ALU_Sel = '0;
  int checks = 0, failures = 0;

  logic [8:0] r1 = '0;
  logic [8:0] r4 [4] = '{default: '0};

  logic [15:0] pass0, fail0, skip0, pass4, fail4, skip4;
  logic [1:0]  pass2, fail2, skip2;
  logic        err0, busy0, done0, err4, busy4, done4, err2, busy2, done2;
`ifdef ALU_CHK_FIRST_FAIL_EN
  logic [7:0] ffa0, ffb0, ffa4, ffb4, ffa2, ffb2;
  logic [3:0] ffs0, ffs4, ffs2;
  logic [8:0] ffe0, ffx0, ffe4, ffx4, ffe2, ffx2;
`endif

  always #5 clock = ~clock;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (s)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b0001: return {1'b0, a} - {1'b0, b};
      4'b0010: return {|p[15:8], p[7:0]};
      4'b0011: return (b != 8'd0) ? {1'b0, a / b} : 9'h000;
      default: return 9'h000;
    endcase
  endfunction

  always @(posedge clock) begin : alu_model
    logic [8:0] v;
    v = alu_f(A, B, ALU_Sel);
    if (fault) v[7:0] = 8'hAC;
    r1 <= v;
    r4[0] <= v;
    for (int i = 1; i < 4; i++) r4[i] <= r4[i-1];
  end

  alu_response_checker #(.LATENCY(1), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(r1[7:0]), .CarryOut(r1[8]),
    .pass_cnt(pass0), .fail_cnt(fail0), .skip_cnt(skip0), .error(err0), .busy(busy0), .done(done0)
`ifdef ALU_CHK_FIRST_FAIL_EN
    , .ff_A(ffa0), .ff_B(ffb0), .ff_sel(ffs0), .ff_exp(ffe0), .ff_act(ffx0)
`endif
  );

  alu_response_checker #(.LATENCY(4), .CNT_W(16)) u4 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(r4[3][7:0]), .CarryOut(r4[3][8]),
    .pass_cnt(pass4), .fail_cnt(fail4), .skip_cnt(skip4), .error(err4), .busy(busy4), .done(done4)
`ifdef ALU_CHK_FIRST_FAIL_EN
    , .ff_A(ffa4), .ff_B(ffb4), .ff_sel(ffs4), .ff_exp(ffe4), .ff_act(ffx4)
`endif
  );

  alu_response_checker #(.LATENCY(1), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(r1[7:0]), .CarryOut(r1[8]),
    .pass_cnt(pass2), .fail_cnt(fail2), .skip_cnt(skip2), .error(err2), .busy(busy2), .done(done2)
`ifdef ALU_CHK_FIRST_FAIL_EN
    , .ff_A(ffa2), .ff_B(ffb2), .ff_sel(ffs2), .ff_exp(ffe2), .ff_act(ffx2)
`endif
  );

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input logic f);
    @(negedge clock);
    A = a; B = b; ALU_Sel = s; in_valid = 1'b1; fault = f;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0; fault = 1'b0; start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    in_valid = 1'b0; fault = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clock);
    in_valid = 1'b0; stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({pass0, fail0, skip0} !== 48'h0) begin
      failures++; $display("FAIL reset_cnt: got %h/%h/%h want 0/0/0", pass0, fail0, skip0);
    end
    checks++;
    if ({err0, busy0, done0} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got err/busy/done=%b%b%b want 000", err0, busy0, done0);
    end
    pulse_stop();
    checks++;
    if ({busy0, done0} !== 2'b00) begin
      failures++; $display("FAIL stop_in_idle: got busy/done=%b%b want 00", busy0, done0);
    end
  endtask

  task automatic test_add();
    pulse_start();
    drive(8'h0A, 8'h05, 4'b0000, 1'b0);
    drive(8'hFF, 8'h01, 4'b0000, 1'b0);
    idle(3);
    checks++;
    if (pass0 !== 16'd2 || fail0 !== 16'd0 || err0 !== 1'b0) begin
      failures++; $display("FAIL add: got pass=%0d fail=%0d err=%b want 2/0/0", pass0, fail0, err0);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      failures++; $display("FAIL add_busy: got %b want 1", busy0);
    end
  endtask

  task automatic test_mul();
    pulse_start();
    drive(8'hFF, 8'h02, 4'b0010, 1'b0);
    drive(8'h0A, 8'h00, 4'b0010, 1'b0);
    idle(3);
    checks++;
    if (pass0 !== 16'd2 || fail0 !== 16'd0) begin
      failures++; $display("FAIL mul: got pass=%0d fail=%0d want 2/0", pass0, fail0);
    end
  endtask

  task automatic test_div_skip();
    pulse_start();
    drive(8'h9B, 8'h0A, 4'b0011, 1'b0);
    drive(8'h02, 8'h00, 4'b0011, 1'b0);
    drive(8'h12, 8'h34, 4'b1000, 1'b0);
    idle(3);
    checks++;
    if (pass0 !== 16'd1 || skip0 !== 16'd2 || fail0 !== 16'd0) begin
      failures++; $display("FAIL div_skip: got pass=%0d skip=%0d fail=%0d want 1/2/0", pass0, skip0, fail0);
    end
  endtask

  task automatic test_fail();
    pulse_start();
    drive(8'h0A, 8'h02, 4'b0001, 1'b1);
    drive(8'h03, 8'h01, 4'b0000, 1'b0);
    idle(3);
    checks++;
    if (fail0 !== 16'd1 || pass0 !== 16'd1 || err0 !== 1'b1) begin
      failures++; $display("FAIL mismatch: got fail=%0d pass=%0d err=%b want 1/1/1", fail0, pass0, err0);
    end
`ifdef ALU_CHK_FIRST_FAIL_EN
    checks++;
    if (ffe0 !== 9'h008 || ffx0 !== 9'h0AC || ffa0 !== 8'h0A || ffb0 !== 8'h02 || ffs0 !== 4'b0001) begin
      failures++; $display("FAIL first_fail: got exp=%h act=%h a=%h b=%h sel=%h want 008/0ac/0a/02/1", ffe0, ffx0, ffa0, ffb0, ffs0);
    end
`endif
    pulse_stop();
    idle(1);
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b1) begin
      failures++; $display("FAIL stop_done: got done=%b busy=%b err=%b want 1/0/1", done0, busy0, err0);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    drive(8'h10, 8'h20, 4'b0000, 1'b0);
    drive(8'h05, 8'h07, 4'b0001, 1'b0);
    drive(8'h03, 8'h04, 4'b0010, 1'b0);
    @(negedge clock);
    in_valid = 1'b0; stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    A = 8'h01; B = 8'h01; ALU_Sel = 4'b0000; in_valid = 1'b1;
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      failures++; $display("FAIL lat4_drain1: got busy=%b done=%b want 1/0", busy4, done4);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0 || pass4 !== 16'd2) begin
      failures++; $display("FAIL lat4_drain3: got busy=%b done=%b pass=%0d want 1/0/2", busy4, done4, pass4);
    end
    @(negedge clock);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b1 || pass4 !== 16'd3) begin
      failures++; $display("FAIL lat4_done: got busy=%b done=%b pass=%0d want 0/1/3", busy4, done4, pass4);
    end
    idle(6);
    pulse_stop();
    checks++;
    if (pass4 !== 16'd3 || fail4 !== 16'd0 || skip4 !== 16'd0 || done4 !== 1'b1) begin
      failures++; $display("FAIL lat4_after_stop: got pass=%0d fail=%0d skip=%0d done=%b want 3/0/0/1", pass4, fail4, skip4, done4);
    end
  endtask

  task automatic test_saturate();
    pulse_start();
    for (int i = 0; i < 5; i++) drive(8'(i), 8'h01, 4'b0000, 1'b0);
    idle(3);
    checks++;
    if (pass2 !== 2'd3 || fail2 !== 2'd0) begin
      failures++; $display("FAIL saturate: got pass=%0d fail=%0d want 3/0", pass2, fail2);
    end
    checks++;
    if (pass0 !== 16'd5) begin
      failures++; $display("FAIL wide_count: got pass=%0d want 5", pass0);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    drive(8'h01, 8'h02, 4'b0000, 1'b0);
    drive(8'h03, 8'h04, 4'b0000, 1'b0);
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle(6);
    checks++;
    if ({pass0, fail0, skip0} !== 48'h0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++; $display("FAIL mid_reset0: got pass=%0d fail=%0d skip=%0d busy=%b done=%b want 0s", pass0, fail0, skip0, busy0, done0);
    end
    checks++;
    if (pass4 !== 16'd0 || busy4 !== 1'b0) begin
      failures++; $display("FAIL mid_reset4: got pass=%0d busy=%b want 0/0", pass4, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_skip();
    test_fail();
    test_back_to_back();
    test_saturate();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
